// File: rtl/char_board_writer_if.sv
// Signal bundle between the board-logic / draw pipeline (master) and the
// character-map writer (slave).
interface char_board_writer_if #(
  parameter int ADDR_W = 10,
  parameter int CODE_W = 7
);
  // Field updates use valid/ready: the master holds wr_valid and the wr_*
  // fields stable until a cycle where wr_valid && wr_ready at the clock edge;
  // that edge transfers exactly one update. The master must not gate
  // wr_valid on wr_ready.
  logic                  clear;
  logic                  busy;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W/2-1:0]   wr_col;
  logic [ADDR_W/2-1:0]   wr_row;
  logic [1:0]            wr_kind;
  logic [3:0]            wr_value;
  logic                  err;
  logic [ADDR_W-1:0]     char_xy;
  logic [CODE_W-1:0]     char_code;
  logic [1:0]            dbg_state;

  modport master (
    output clear, wr_valid, wr_col, wr_row, wr_kind, wr_value, char_xy,
    input  busy, wr_ready, err, char_code, dbg_state
  );

  modport slave (
    input  clear, wr_valid, wr_col, wr_row, wr_kind, wr_value, char_xy,
    output busy, wr_ready, err, char_code, dbg_state
  );
endinterface

// File: rtl/char_board_writer.sv
// Character-map writer: owns the {col,row} character RAM, encodes game field
// updates into character codes, blanks the map, and serves registered reads.
module char_board_writer #(
  parameter int                 ADDR_W     = 10,
  parameter int                 CODE_W     = 7,
  parameter logic [CODE_W-1:0]  BLANK_CODE = 7'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  char_board_writer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   sweep_addr;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [CODE_W-1:0]   wr_code_q;
  logic                err_q;
  logic [CODE_W-1:0]   char_code_q;

  logic [CODE_W-1:0]   mem [DEPTH];

  logic                accept;
  logic [CODE_W-1:0]   enc_code;
  logic                enc_bad;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [CODE_W-1:0]   mem_wdata;

  // clear has priority over a pending update in IDLE, so ready drops with it.
  assign bus.wr_ready  = (state == ST_IDLE) && !bus.clear;
  assign bus.busy      = (state == ST_CLEAR);
  assign bus.err       = err_q;
  assign bus.char_code = char_code_q;
  assign bus.dbg_state = state;
  assign accept        = bus.wr_valid && bus.wr_ready;

  always_comb begin
    enc_code = BLANK_CODE;
    enc_bad  = 1'b0;
    case (bus.wr_kind)
      2'd0: enc_code = CODE_W'(7'h23);
      2'd1: begin
        if (bus.wr_value == 4'd0) begin
          enc_code = BLANK_CODE;
        end else if (bus.wr_value <= 4'd8) begin
          enc_code = CODE_W'(7'h30) + CODE_W'(bus.wr_value);
        end else begin
          enc_code = CODE_W'(7'h3F);
          enc_bad  = 1'b1;
        end
      end
      2'd2: enc_code = CODE_W'(7'h46);
      default: enc_code = CODE_W'(7'h2A);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      sweep_addr <= '0;
      wr_addr_q  <= '0;
      wr_code_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (bus.clear) begin
            sweep_addr <= '0;
          end else if (sweep_addr == {ADDR_W{1'b1}}) begin
            sweep_addr <= '0;
            state      <= ST_IDLE;
          end else begin
            sweep_addr <= sweep_addr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.clear) begin
            sweep_addr <= '0;
            state      <= ST_CLEAR;
          end else if (accept) begin
            wr_addr_q <= {bus.wr_col, bus.wr_row};
            wr_code_q <= enc_code;
            err_q     <= enc_bad;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // The accept cycle can never see clear (ready is low then), so only
          // the current cycle's clear decides between sweep and idle.
          sweep_addr <= '0;
          state      <= bus.clear ? ST_CLEAR : ST_IDLE;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sweep_addr;
    mem_wdata = BLANK_CODE;
    if (rst_n && state == ST_CLEAR) begin
      mem_we = 1'b1;
    end else if (rst_n && state == ST_WRITE) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr_q;
      mem_wdata = wr_code_q;
    end
  end

  // No reset on the array; the sweep owns its initial contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      char_code_q <= '0;
    end else begin
      char_code_q <= mem[bus.char_xy];
    end
  end
endmodule

// File: tb/tb_char_board_writer.sv
// Directed bench for char_board_writer: sweep timing, encoding, handshake
// rate, clear priority, reset restart and read-first collision.
module tb_char_board_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  char_board_writer_if bus ();

  char_board_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts samples with busy high, starting at the current one.
  task automatic wait_idle(input string tag, input int exp_n);
    int n = 0;
    while (bus.busy === 1'b1 && n < 3000) begin
      n++;
      tick();
    end
    check(tag, n, exp_n);
  endtask

  task automatic rd(input string tag, input logic [9:0] addr, input logic [6:0] exp);
    bus.char_xy = addr;
    tick();
    check(tag, bus.char_code, exp);
  endtask

  task automatic wr(input string tag, input logic [4:0] col, input logic [4:0] row,
                    input logic [1:0] kind, input logic [3:0] val, input logic exp_err);
    int n = 0;
    while (bus.wr_ready !== 1'b1 && n < 50) begin
      n++;
      tick();
    end
    check({tag, "_ready"}, bus.wr_ready, 1);
    bus.wr_col   = col;
    bus.wr_row   = row;
    bus.wr_kind  = kind;
    bus.wr_value = val;
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    check({tag, "_busy_ready"}, bus.wr_ready, 0);
    check({tag, "_err"}, bus.err, exp_err);
    tick();
    check({tag, "_ready_again"}, bus.wr_ready, 1);
    check({tag, "_err_gone"}, bus.err, 0);
  endtask

  logic [4:0] s_col  [3] = '{5'd1, 5'd2, 5'd4};
  logic [4:0] s_row  [3] = '{5'd1, 5'd2, 5'd7};
  logic [1:0] s_kind [3] = '{2'd0, 2'd2, 2'd3};
  int         acc_cyc[3];

  initial begin
    int idx;
    int cyc;
    logic rdy;
    bus.clear    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_col   = '0;
    bus.wr_row   = '0;
    bus.wr_kind  = '0;
    bus.wr_value = '0;
    bus.char_xy  = '0;
    rst_n        = 1'b0;
    tick();
    tick();
    check("rst_busy", bus.busy, 1);
    check("rst_ready", bus.wr_ready, 0);
    check("rst_code", bus.char_code, 0);
    check("rst_err", bus.err, 0);
    check("rst_state", bus.dbg_state, 0);

    rst_n = 1'b1;
    wait_idle("sweep_first", 1024);
    check("idle_ready", bus.wr_ready, 1);
    check("idle_state", bus.dbg_state, 1);
    for (int a = 0; a < 1024; a++) begin
      rd("blank_all", 10'(a), 7'h20);
    end

    // col 3 row 5 -> 0x065, number 4 -> '4'
    wr("num4", 5'd3, 5'd5, 2'd1, 4'd4, 1'b0);
    rd("num4_read", 10'h065, 7'h34);

    // Back-to-back valid: accepts must land on every other cycle.
    idx = 0;
    cyc = 0;
    bus.wr_valid = 1'b1;
    bus.wr_value = 4'd0;
    while (idx < 3 && cyc < 20) begin
      bus.wr_col  = s_col[idx];
      bus.wr_row  = s_row[idx];
      bus.wr_kind = s_kind[idx];
      rdy = bus.wr_ready;
      tick();
      if (rdy) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      cyc++;
    end
    bus.wr_valid = 1'b0;
    tick();
    check("stream_accepts", idx, 3);
    check("stream_cycles", cyc, 5);
    check("stream_acc1", acc_cyc[1], 2);
    check("stream_acc2", acc_cyc[2], 4);
    rd("hidden_read", 10'h021, 7'h23);
    rd("flag_read", 10'h042, 7'h46);
    rd("mine_read", 10'h087, 7'h2A);

    wr("num9", 5'd10, 5'd20, 2'd1, 4'd9, 1'b1);
    rd("num9_read", 10'h154, 7'h3F);
    wr("num8", 5'd31, 5'd31, 2'd1, 4'd8, 1'b0);
    rd("num8_read", 10'h3FF, 7'h38);
    wr("mine1", 5'd0, 5'd1, 2'd3, 4'd0, 1'b0);
    rd("mine1_read", 10'h001, 7'h2A);
    wr("num0", 5'd0, 5'd1, 2'd1, 4'd0, 1'b0);
    rd("num0_read", 10'h001, 7'h20);

    // Read-first: the read sampled on the write edge returns the old code.
    wr("pre_mine", 5'd5, 5'd5, 2'd3, 4'd0, 1'b0);
    bus.char_xy = 10'h0A5;
    wr("coll_flag", 5'd5, 5'd5, 2'd2, 4'd0, 1'b0);
    check("coll_old", bus.char_code, 7'h2A);
    tick();
    check("coll_new", bus.char_code, 7'h46);

    // clear wins over a simultaneous update in IDLE.
    bus.wr_col   = 5'd5;
    bus.wr_row   = 5'd5;
    bus.wr_kind  = 2'd0;
    bus.wr_valid = 1'b1;
    bus.clear    = 1'b1;
    #1;
    check("clr_blocks_ready", bus.wr_ready, 0);
    tick();
    bus.clear    = 1'b0;
    bus.wr_valid = 1'b0;
    check("clr_busy", bus.busy, 1);
    wait_idle("sweep_clr", 1024);
    rd("clr_target", 10'h0A5, 7'h20);
    rd("clr_old", 10'h065, 7'h20);

    // clear during WRITE: the write lands, then the sweep blanks it.
    bus.wr_kind  = 2'd2;
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    check("cw_in_write", bus.dbg_state, 2);
    bus.clear   = 1'b1;
    bus.char_xy = 10'h0A5;
    tick();
    bus.clear = 1'b0;
    check("cw_busy", bus.busy, 1);
    check("cw_read_first", bus.char_code, 7'h20);
    tick();
    check("cw_landed", bus.char_code, 7'h46);
    wait_idle("sweep_cw", 1023);
    rd("cw_blanked", 10'h0A5, 7'h20);

    // Reset at sweep address 500 restarts a full sweep.
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (500) tick();
    check("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_code", bus.char_code, 0);
    check("mid_rst_ready", bus.wr_ready, 0);
    wait_idle("sweep_reset", 1024);
    rd("reset_blank", 10'h3FF, 7'h20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/char_board_writer.md
Name: char_board_writer

Overview:
- Writer side of the character-map interface used by the board text overlay.
- Owns a 1024-entry character-code RAM addressed by {col,row} (5+5 bits) and converts game field updates (hidden/number/flag/mine) into character codes.
- Clears the map to blanks on reset or request.
- Serves the draw pipeline's char_xy lookups with 1-cycle registered read latency; the returned code feeds the font ROM.

Parameters:
- ADDR_W, 10, char map address width ({col[4:0],row[4:0]}); depth = 2**ADDR_W.
- CODE_W, 7, character code width.
- BLANK_CODE, 7'h20, code written by clear sweep and for revealed-zero fields.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- clear  input  1  request full-map clear (level sampled each cycle)
- busy  output  1  high while clear sweep in progress
- wr_valid  input  1  field update request
- wr_ready  output  1  writer can accept update this cycle
- wr_col  input  5  field column
- wr_row  input  5  field row
- wr_kind  input  2  0=hidden, 1=revealed number, 2=flag, 3=mine
- wr_value  input  4  neighbour count, meaningful when wr_kind=1
- err  output  1  one-cycle pulse: illegal value accepted
- char_xy  input  10  read address {col,row} from draw pipeline
- char_code  output  7  registered character code for char_xy

Behaviour:
- Reset (rst_n=0 at clk edge): state<=CLEAR, sweep addr<=0, char_code<=0, err<=0. busy=1 and wr_ready=0 from the first cycle after reset. RAM contents are not reset; the sweep overwrites them.
- FSM states: CLEAR, IDLE, WRITE.
- CLEAR:
  - Writes BLANK_CODE to sweep addr each cycle, then addr+1, in order 0..1023.
  - After the write to 1023, next state is IDLE and busy drops that same edge. A full sweep holds busy for exactly 1024 cycles.
  - clear=1 while in CLEAR restarts the sweep at 0.
  - wr_ready=0 throughout.
- IDLE:
  - wr_ready=1, busy=0.
  - clear=1 has priority: go to CLEAR with addr 0, and a simultaneous wr_valid is not accepted (wr_ready is combinationally 0 when clear=1).
  - Otherwise, wr_valid&&wr_ready latches address {wr_col,wr_row} and the encoded code, then goes to WRITE.
- WRITE:
  - Performs the RAM write of the latched code; wr_ready=0.
  - Next state is CLEAR if clear=1 this cycle or clear was seen during the accept cycle; otherwise IDLE.
  - Maximum accept rate: 1 per 2 cycles.
- Encoding:
  - kind0 -> 7'h23 '#'
  - kind1 value 0 -> BLANK_CODE
  - kind1 value 1..8 -> 7'h30+value
  - kind1 value 9..15 -> 7'h3F '?', with err=1 for exactly one cycle (the WRITE cycle)
  - kind2 -> 7'h46 'F'
  - kind3 -> 7'h2A '*'
- Read port:
  - char_code <= RAM[char_xy] every cycle, 1-cycle latency.
  - Reads proceed in all states; reads during CLEAR return partially cleared contents.
  - A read and write to the same address in the same cycle returns old data (read-first).
- Write address is always in range (10 bits = full depth); no wrap logic is needed beyond the sweep counter rolling to IDLE.
- Reset asserted mid-WRITE or mid-CLEAR: the pending write is dropped and the sweep restarts from 0.

Test Plan:
- Release reset, hold clear=0 -> busy=1 for exactly 1024 cycles, then wr_ready=1. Read every address -> char_code=7'h20 one cycle after each char_xy.
- After clear, write col=3 row=5 kind=1 value=4 -> accepted in 1 cycle, wr_ready 1,0,1. char_xy=10'h065 then gives char_code=7'h34 the cycle after the read, when issued 2+ cycles after accept.
- Hold wr_valid high with kinds 0/2/3 to three addresses -> accepts every other cycle. Codes read back 0x23, 0x46, 0x2A; the number of accepts equals the number of wr_valid&&wr_ready cycles.
- Write kind=1 value=9 -> err pulses exactly one cycle and the address reads 7'h3F. Value 0 reads 7'h20.
- clear and wr_valid together in IDLE -> write not accepted, busy for 1024 cycles, target address reads 0x20. clear during WRITE -> the write lands and is then blanked by the sweep.
- rst_n low for 1 cycle at sweep address 500, then released -> busy for a fresh 1024 cycles. Same-address read/write collision returns the previous code.
